// File: rtl/ysyx_23060187_pc_gen_pkg.sv
// Shared types and constants for the NPC program-counter unit:
// FSM states, branch funct3 codes, sequential step and a saturating counter helper.
package ysyx_23060187_pc_pkg;

    typedef enum logic [1:0] {
        BOOT      = 2'd0,
        RUN       = 2'd1,
        WAIT_TRAP = 2'd2,
        HALT      = 2'd3
    } pc_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned PC_STEP = 4;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ysyx_23060187_pc_gen_if.sv
// Fetch-side handshake between the PC generator (master) and the IFU (slave).
interface ysyx_23060187_pc_gen_if #(
    parameter int XLEN = 32
);
    logic            pc_valid;
    logic            pc_ready;
    logic [XLEN-1:0] pc_out;
    logic            redirect;

    modport master (output pc_valid, pc_out, redirect, input pc_ready);
    modport slave  (input  pc_valid, pc_out, redirect, output pc_ready);
endinterface

// File: rtl/ysyx_23060187_pc_gen_br_cmp.sv
// Combinational branch-condition resolver: funct3 selects eq / signed lt / unsigned lt.
module ysyx_23060187_br_cmp
    import ysyx_23060187_pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      br_type_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic            taken_o
);
    logic eq, lt_s, lt_u;

    assign eq   = (src1_i == src2_i);
    assign lt_s = ($signed(src1_i) < $signed(src2_i));
    assign lt_u = (src1_i < src2_i);

    // NOTE: a default before the case keeps undefined funct3 from inferring a latch.
    always_comb begin
        taken_o = 1'b0;
        case (br_type_i)
            F3_BEQ:  taken_o = eq;
            F3_BNE:  taken_o = !eq;
            F3_BLT:  taken_o = lt_s;
            F3_BGE:  taken_o = !lt_s;
            F3_BLTU: taken_o = lt_u;
            F3_BGEU: taken_o = !lt_u;
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/ysyx_23060187_pc_gen.sv
// Fetch PC generator with JAL/JALR/branch/trap redirects, misalign parking and ebreak halt.
// Define YSYX_23060187_PC_PERF_EN to add saturating redirect/branch performance counters.
module ysyx_23060187_pc_gen
    import ysyx_23060187_pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
    parameter int              IALIGN_BITS  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ysyx_23060187_pc_gen_if.master fetch,
    input  logic                   ex_valid,
    input  logic                   ex_jal,
    input  logic                   ex_jalr,
    input  logic                   ex_br,
    input  logic [2:0]             ex_br_type,
    input  logic [XLEN-1:0]        ex_pc,
    input  logic [XLEN-1:0]        ex_src1,
    input  logic [XLEN-1:0]        ex_src2,
    input  logic [XLEN-1:0]        ex_imm,
    input  logic                   trap_valid,
    input  logic [XLEN-1:0]        trap_target,
    input  logic                   halt_req,
    output logic                   misalign,
    output logic [XLEN-1:0]        misalign_addr
`ifdef YSYX_23060187_PC_PERF_EN
    ,
    output logic [31:0]            perf_redirects,
    output logic [31:0]            perf_br_taken,
    output logic [31:0]            perf_br_not_taken
`endif
);
    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, misalign_addr_q, misalign_addr_d;
    logic            redirect_q, redirect_d, misalign_q, misalign_d;
    logic            br_taken, ex_taken, ex_misaligned;
    logic [XLEN-1:0] jalr_sum, ex_target;

    ysyx_23060187_br_cmp #(.XLEN(XLEN)) u_br_cmp (
        .br_type_i (ex_br_type),
        .src1_i    (ex_src1),
        .src2_i    (ex_src2),
        .taken_o   (br_taken)
    );

    // JALR wins over JAL, JAL over branch if the decoder ever asserts more than one.
    assign jalr_sum      = ex_src1 + ex_imm;
    assign ex_target     = ex_jalr ? (jalr_sum & ~XLEN'(1)) : (ex_pc + ex_imm);
    assign ex_taken      = ex_valid & (ex_jalr | ex_jal | (ex_br & br_taken));
    assign ex_misaligned = |ex_target[IALIGN_BITS-1:0];

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        misalign_addr_d = misalign_addr_q;
        redirect_d      = 1'b0;
        misalign_d      = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (trap_valid) begin
                    pc_d       = trap_target;
                    redirect_d = 1'b1;
                end else if (ex_taken) begin
                    if (ex_misaligned) begin
                        misalign_d      = 1'b1;
                        misalign_addr_d = ex_target;
                        state_d         = WAIT_TRAP;
                    end else begin
                        pc_d       = ex_target;
                        redirect_d = 1'b1;
                    end
                end else if (fetch.pc_ready) begin
                    pc_d = pc_q + XLEN'(PC_STEP);
                end
            end
            WAIT_TRAP: begin
                if (halt_req) begin
                    state_d = HALT;
                end else if (trap_valid) begin
                    pc_d       = trap_target;
                    redirect_d = 1'b1;
                    state_d    = RUN;
                end
            end
            HALT: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= BOOT;
            pc_q            <= RESET_VECTOR;
            misalign_addr_q <= '0;
            redirect_q      <= 1'b0;
            misalign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            misalign_addr_q <= misalign_addr_d;
            redirect_q      <= redirect_d;
            misalign_q      <= misalign_d;
        end
    end

    assign fetch.pc_valid = (state_q == RUN);
    assign fetch.pc_out   = pc_q;
    assign fetch.redirect = redirect_q;
    assign misalign       = misalign_q;
    assign misalign_addr  = misalign_addr_q;

`ifdef YSYX_23060187_PC_PERF_EN
    logic        run_free, br_sel, redirect_ev;
    logic [31:0] perf_redirects_q, perf_br_taken_q, perf_br_not_taken_q;

    // Events count only when nothing of higher priority pre-empts them in RUN.
    assign run_free    = (state_q == RUN) & !halt_req;
    assign redirect_ev = run_free & (trap_valid | (ex_taken & !ex_misaligned));
    assign br_sel      = run_free & !trap_valid & ex_valid & ex_br & !ex_jal & !ex_jalr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_redirects_q    <= '0;
            perf_br_taken_q     <= '0;
            perf_br_not_taken_q <= '0;
        end else begin
            if (redirect_ev)          perf_redirects_q    <= sat_inc32(perf_redirects_q);
            if (br_sel && br_taken)   perf_br_taken_q     <= sat_inc32(perf_br_taken_q);
            if (br_sel && !br_taken)  perf_br_not_taken_q <= sat_inc32(perf_br_not_taken_q);
        end
    end

    assign perf_redirects    = perf_redirects_q;
    assign perf_br_taken     = perf_br_taken_q;
    assign perf_br_not_taken = perf_br_not_taken_q;
`endif

    ex_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
        ex_valid |-> $onehot0({ex_jal, ex_jalr, ex_br}));

endmodule

// File: doc/ysyx_23060187_pc_gen.md
Name: ysyx_23060187_pc_gen

Overview:
Parametrised next-generation program-counter unit for the NPC core. Holds the fetch PC and offers it to IFU over a valid/ready handshake. Resolves branch condition internally from register operands and applies JAL/JALR/branch/trap redirects with fixed priority. Detects misaligned targets and parks until the trap path redirects; supports halt on ebreak.

Parameters:
XLEN, 32, datapath/PC width
RESET_VECTOR, 32'h8000_0000, PC value after reset (XLEN bits)
IALIGN_BITS, 2, low target bits that must be zero (2 = RV32I, 1 = with C ext)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_valid  out  1  pc_out is a valid fetch request
pc_ready  in  1  IFU accepts pc_out this cycle
pc_out  out  XLEN  current fetch PC
ex_valid  in  1  control-flow instruction resolving this cycle
ex_jal  in  1  JAL
ex_jalr  in  1  JALR
ex_br  in  1  conditional branch
ex_br_type  in  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
ex_pc  in  XLEN  PC of resolving instruction
ex_src1  in  XLEN  rs1 value
ex_src2  in  XLEN  rs2 value
ex_imm  in  XLEN  sign-extended immediate
trap_valid  in  1  trap/mret redirect
trap_target  in  XLEN  trap vector or mepc
halt_req  in  1  ebreak retired
redirect  out  1  one-cycle pulse: younger instructions must flush
misalign  out  1  one-cycle pulse: misaligned target detected
misalign_addr  out  XLEN  offending target, held until next misalign

Behaviour:
- Reset (async, rst_n=0): pc_out=RESET_VECTOR, pc_valid=0, redirect=0, misalign=0, misalign_addr=0, state=BOOT.
- States: BOOT -> RUN unconditionally next cycle (pc_valid rises one cycle after reset release). RUN: pc_valid=1. WAIT_TRAP: pc_valid=0, waiting for trap_valid. HALT: pc_valid=0, left only by reset.
- Targets: JAL/branch = ex_pc + ex_imm; JALR = (ex_src1 + ex_imm) with bit0 cleared; all mod 2^XLEN (wrap, no overflow flag). Sequential = pc_out + 4, wraps.
- Branch taken: BEQ eq, BNE !eq, BLT/BGE signed lt/!lt, BLTU/BGEU unsigned lt/!lt. Undefined funct3 (010, 011) = not taken.
- Priority per cycle in RUN: halt_req > trap_valid > taken ex (ex_valid & (ex_jal | ex_jalr | ex_br&taken)) > sequential advance (pc_valid & pc_ready) > hold.
- Redirect (trap or taken ex, target aligned): pc_out <= target next edge, redirect=1 that cycle (registered, asserted the cycle pc_out changes). Redirect overrides a pending unaccepted request: pc_out may change while pc_valid=1 & !pc_ready; IFU drops the old request on redirect.
- Not-taken branch: no redirect, no effect on PC.
- Misaligned ex target (target[IALIGN_BITS-1:0] != 0): pc_out unchanged, misalign pulse, misalign_addr <= target, state -> WAIT_TRAP. Trap targets are never checked.
- WAIT_TRAP: ignores ex_* and pc_ready; trap_valid -> pc_out<=trap_target, redirect pulse, -> RUN. halt_req -> HALT.
- halt_req in any non-BOOT state -> HALT next edge, pc_out frozen, simultaneous redirect ignored.
- Multiple ex_jal/ex_jalr/ex_br asserted together: illegal; assertion in sim; RTL priority jalr > jal > br.

Optional Feature:
YSYX_23060187_PC_PERF_EN: adds outputs perf_redirects, perf_br_taken, perf_br_not_taken (32 bits each, saturating at all-ones, reset 0, count per qualifying cycle in RUN). Without macro: ports and counters absent, no other behavioural change.

Decomposition:
- Package ysyx_23060187_pc_pkg: state enum (BOOT, RUN, WAIT_TRAP, HALT), funct3 localparams for the six branch types, sequential increment constant 4.
- Sub-module ysyx_23060187_br_cmp: combinational taken-resolution from br_type, src1, src2 (eq/signed lt/unsigned lt).

Test Plan:
- Reset release: pc_out=32'h8000_0000, pc_valid=0 first cycle, 1 next; pc_ready=1 for 3 cycles -> 8000_0004, 8000_0008, 8000_000C.
- BLT ex_pc=8000_0010, src1=32'hFFFF_FFFF, src2=1, imm=-16 -> taken, pc_out=8000_0000, redirect pulse; same operands BLTU -> not taken, no redirect.
- JALR src1=8000_0101, imm=3 -> target 8000_0104, redirect; with IALIGN_BITS=2 and imm=1 (target 8000_0102) -> misalign pulse, misalign_addr=8000_0102, pc_valid=0 until trap_valid with 8000_0200 -> pc_out=8000_0200, RUN.
- Redirect while pc_valid=1, pc_ready=0 and simultaneous trap_valid + JAL -> trap_target wins, one redirect pulse.
- Wrap: pc_out=FFFF_FFFC, accept -> 0000_0000; halt_req with simultaneous JAL -> HALT, pc_out frozen, pc_valid=0; rst_n low mid-HALT -> RESET_VECTOR immediately (async).
